register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle processor datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits between instruction decode (register addresses) and the ALU / writeback mux (writeData).
- Register 0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register address; depth is 2**ADDR_WIDTH (32 entries).

Ports:
- clock  input  1  system clock; writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all registers.
- RegWrite  input  1  write enable, sampled on the rising edge of clock.
- Read_Reg1  input  ADDR_WIDTH  read port 1 address.
- Read_Reg2  input  ADDR_WIDTH  read port 2 address.
- Write_Reg  input  ADDR_WIDTH  write port address.
- writeData  input  DATA_WIDTH  write port data.
- Read_Data1  output  DATA_WIDTH  contents of register Read_Reg1.
- Read_Data2  output  DATA_WIDTH  contents of register Read_Reg2.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high (clock, rst).
- Reset:
  - rst=1 immediately clears all 32 registers to 0, without waiting for a clock edge.
  - Read_Data1 and Read_Data2 therefore read 0 while rst is high.
  - Writes are ignored while rst=1, including a rising edge coinciding with rst=1.
  - Reset asserted mid-operation discards all prior contents.
- Write:
  - On the rising edge of clock, with rst=0 and RegWrite=1, reg[Write_Reg] <= writeData.
  - RegWrite=0: no register changes.
  - Write_Reg=0: the write is silently discarded; reg[0] stays 0.
- Read:
  - Purely combinational, no clock latency: Read_Data1 = reg[Read_Reg1], Read_Data2 = reg[Read_Reg2].
  - Outputs follow address changes within the same cycle.
  - Address 0 always returns 0.
- Write-to-read timing:
  - No internal write-first bypass.
  - A value written at edge N is visible on the read ports immediately after edge N.
  - Before edge N, a read of the same address returns the old value.
- Both read ports may address the same register, including the one being written; each returns the same stored value.
- No unknown values on the outputs after the first reset.
- No other state. The write address is 5 bits, so all 32 addresses are valid and there are no out-of-range addresses.

Test Plan:
- Reset: assert rst=1 for 10 ns, then release. Read_Reg1=3, Read_Reg2=4 -> Read_Data1=0, Read_Data2=0.
- Write then read:
  - Write_Reg=3, writeData=32'hAABBCCDD, RegWrite=1, Read_Reg1=3, Read_Reg2=4, one rising edge.
  - -> Read_Data1=32'hAABBCCDD, Read_Data2=0.
- Second write:
  - Write_Reg=5, writeData=32'h11223344, RegWrite=1, Read_Reg1=5, Read_Reg2=7, one edge.
  - -> Read_Data1=32'h11223344, Read_Data2=0; register 3 still reads 32'hAABBCCDD.
- Write disable and x0:
  - RegWrite=0, Write_Reg=3, writeData=32'hDEADBEEF, one edge -> reg 3 still 32'hAABBCCDD.
  - Then RegWrite=1, Write_Reg=0, writeData=32'hFFFFFFFF, one edge -> Read_Reg1=0 gives 0.
- Timing:
  - Just before an edge writing 32'h12345678 to reg 9, a read of reg 9 returns the old value (0).
  - Immediately after that edge it returns 32'h12345678.
  - Both ports reading reg 9 return the same value.
- Asynchronous reset mid-run: with regs 3 and 5 loaded, pulse rst between clock edges -> both ports read 0 at once, before the next edge.

Source files
------------

// File: rtl/register_file_if.sv
// Register file access bus: decode/writeback side (master) to register array (slave).
interface register_file_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
);
   logic                  RegWrite;
   logic [ADDR_WIDTH-1:0] Read_Reg1;
   logic [ADDR_WIDTH-1:0] Read_Reg2;
   logic [ADDR_WIDTH-1:0] Write_Reg;
   logic [DATA_WIDTH-1:0] writeData;
   logic [DATA_WIDTH-1:0] Read_Data1;
   logic [DATA_WIDTH-1:0] Read_Data2;

   modport master (
      output RegWrite, Read_Reg1, Read_Reg2, Write_Reg, writeData,
      input  Read_Data1, Read_Data2
   );

   modport slave (
      input  RegWrite, Read_Reg1, Read_Reg2, Write_Reg, writeData,
      output Read_Data1, Read_Data2
   );
endinterface

// File: rtl/register_file.sv
// 32 x 32 register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, asynchronous active-high clear.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input logic                clock,
   input logic                rst,
   register_file_if.slave     rf
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  wr_en_c;

   // Writes to address 0 are dropped so entry 0 never leaves its reset value.
   assign wr_en_c = rf.RegWrite && (rf.Write_Reg != '0);

   // Register array: cleared asynchronously by rst, written on the rising clock edge.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en_c) begin
         regs[rf.Write_Reg] <= rf.writeData;
      end
   end

   // Combinational reads with no write bypass; address 0 forced to zero.
   always_comb begin
      rf.Read_Data1 = '0;
      rf.Read_Data2 = '0;
      if (rf.Read_Reg1 != '0) rf.Read_Data1 = regs[rf.Read_Reg1];
      if (rf.Read_Reg2 != '0) rf.Read_Data2 = regs[rf.Read_Reg2];
   end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps followed by randomized traffic
// compared against an array model of the 32 registers.
module tb_register_file;
   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned DEPTH = 32;

   logic clock = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   logic [DW-1:0] model [DEPTH];

   register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .rst   (rst),
      .rf    (rf.slave)
   );

   always #5 clock = ~clock;

   // Hard stop if the sequence ever stalls.
   initial begin
      #2_000_000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      return (a == '0) ? '0 : model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      rf.Read_Reg1 = a1;
      rf.Read_Reg2 = a2;
      #1;
      check({tag, "_rd1"}, rf.Read_Data1, ref_read(a1));
      check({tag, "_rd2"}, rf.Read_Data2, ref_read(a2));
   endtask

   task automatic write_cycle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      @(negedge clock);
      rf.RegWrite  = we;
      rf.Write_Reg = wa;
      rf.writeData = wd;
      @(posedge clock);
      if (we && wa != '0) model[wa] = wd;
      #1;
      rf.RegWrite = 1'b0;
   endtask

   // Pulse rst between clock edges and confirm the clear is immediate.
   task automatic mid_reset(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      @(negedge clock);
      #1;
      rst = 1'b1;
      clear_model();
      read_check(tag, a1, a2);
      rst = 1'b0;
   endtask

   initial begin
      logic          we;
      logic [AW-1:0] wa, ra1, ra2;
      logic [DW-1:0] wd;

      clear_model();
      rst          = 1'b1;
      rf.RegWrite  = 1'b1;
      rf.Write_Reg = AW'(3);
      rf.writeData = 32'hCAFE_F00D;
      rf.Read_Reg1 = AW'(3);
      rf.Read_Reg2 = AW'(4);

      // Reset held across a rising edge with RegWrite=1: write must be ignored.
      #8;
      check("in_reset_rd1", rf.Read_Data1, 32'h0);
      check("in_reset_rd2", rf.Read_Data2, 32'h0);
      #2;
      rst         = 1'b0;
      rf.RegWrite = 1'b0;
      read_check("post_reset", AW'(3), AW'(4));

      write_cycle(1'b1, AW'(3), 32'hAABB_CCDD);
      read_check("wr3", AW'(3), AW'(4));
      check("wr3_const", rf.Read_Data1, 32'hAABB_CCDD);

      write_cycle(1'b1, AW'(5), 32'h1122_3344);
      read_check("wr5", AW'(5), AW'(7));
      check("wr5_const", rf.Read_Data1, 32'h1122_3344);
      read_check("keep3", AW'(3), AW'(3));
      check("keep3_const", rf.Read_Data2, 32'hAABB_CCDD);

      write_cycle(1'b0, AW'(3), 32'hDEAD_BEEF);
      read_check("we0", AW'(3), AW'(0));
      check("we0_const", rf.Read_Data1, 32'hAABB_CCDD);

      write_cycle(1'b1, AW'(0), 32'hFFFF_FFFF);
      read_check("x0", AW'(0), AW'(0));
      check("x0_const", rf.Read_Data1, 32'h0);

      // Old value visible before the edge, new value right after it.
      @(negedge clock);
      rf.RegWrite  = 1'b1;
      rf.Write_Reg = AW'(9);
      rf.writeData = 32'h1234_5678;
      rf.Read_Reg1 = AW'(9);
      rf.Read_Reg2 = AW'(9);
      #1;
      check("pre_edge_rd1", rf.Read_Data1, 32'h0);
      check("pre_edge_rd2", rf.Read_Data2, 32'h0);
      @(posedge clock);
      model[9] = 32'h1234_5678;
      #1;
      rf.RegWrite = 1'b0;
      check("post_edge_rd1", rf.Read_Data1, 32'h1234_5678);
      check("post_edge_rd2", rf.Read_Data2, 32'h1234_5678);

      mid_reset("mid_rst", AW'(3), AW'(5));
      check("mid_rst_const", rf.Read_Data1, 32'h0);
      write_cycle(1'b0, AW'(3), 32'h0BAD_0BAD);
      read_check("after_rst", AW'(3), AW'(5));

      // Randomized traffic against the model, with occasional asynchronous clears.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            mid_reset("rnd_rst", AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
         end else begin
            we  = 1'($urandom_range(0, 3) != 0);
            wa  = AW'($urandom_range(0, 31));
            wd  = DW'($urandom);
            ra1 = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? ra1 : AW'($urandom_range(0, 31));
            @(negedge clock);
            rf.RegWrite  = we;
            rf.Write_Reg = wa;
            rf.writeData = wd;
            read_check("rnd_pre", ra1, ra2);
            @(posedge clock);
            if (we && wa != '0) model[wa] = wd;
            #1;
            rf.RegWrite = 1'b0;
            read_check("rnd_post", ra1, ra2);
         end
      end

      // Sweep every address on both ports.
      for (int a = 0; a < int'(DEPTH); a++) begin
         read_check("sweep", AW'(a), AW'(DEPTH - 1 - a));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
